// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory port arbiter.
package mem_arb_pkg;

  // Transaction sequencing states; IDLE must encode as zero.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Current bus owner.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Beat counter width for a burst of the given length.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

  // Width needed to hold 0..max inclusive.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction fetch and memory stage requests.
// DM has priority unless IF has lost STARVE_MAX times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned STARVE_W   = cnt_w(STARVE_MAX)
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                win_valid_c,
  output logic                win_if_c
);

  // Any request wins something; IF wins alone or once starved.
  always_comb begin
    win_valid_c = if_req | dm_req;
    win_if_c    = if_req & (~dm_req | (starve_cnt >= STARVE_W'(STARVE_MAX)));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between IF (line fills) and DM (loads/stores).
// Each transaction runs command, optional read beats, then a one-cycle done.
// Optional build macro: MEM_ARB_PERF_EN adds grant and wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned BEATS      = 8,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam int unsigned BEAT_W   = beat_w(BEATS);
  localparam int unsigned STARVE_W = cnt_w(STARVE_MAX);

  state_t              state, state_n;
  owner_t              owner, owner_n;
  logic [BEAT_W-1:0]   beat_cnt, beat_n;
  logic [STARVE_W-1:0] starve_cnt, starve_n;

  logic              if_gnt_n, if_rvalid_n, if_done_n;
  logic              dm_gnt_n, dm_rvalid_n, dm_done_n;
  logic [DATA_W-1:0] rdata_n;
  logic              bus_req_n, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wdata_n;

  logic win_valid_c, win_if_c, last_beat_c;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .STARVE_W   (STARVE_W)
  ) u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .starve_cnt  (starve_cnt),
    .win_valid_c (win_valid_c),
    .win_if_c    (win_if_c)
  );

  // DM loads are single-beat; IF fills run the full burst.
  assign last_beat_c = (owner == OWN_DM) || (beat_cnt == BEAT_W'(BEATS - 1));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_done    <= 1'b0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_done    <= 1'b0;
      rdata      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      beat_cnt   <= beat_n;
      starve_cnt <= starve_n;
      if_gnt     <= if_gnt_n;
      if_rvalid  <= if_rvalid_n;
      if_done    <= if_done_n;
      dm_gnt     <= dm_gnt_n;
      dm_rvalid  <= dm_rvalid_n;
      dm_done    <= dm_done_n;
      rdata      <= rdata_n;
      bus_req    <= bus_req_n;
      bus_we     <= bus_we_n;
      bus_addr   <= bus_addr_n;
      bus_wdata  <= bus_wdata_n;
    end
  end

  // Next state and next output values; strobes default low, the rest hold.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    beat_n      = beat_cnt;
    starve_n    = starve_cnt;
    if_gnt_n    = if_gnt;
    dm_gnt_n    = dm_gnt;
    if_rvalid_n = 1'b0;
    dm_rvalid_n = 1'b0;
    if_done_n   = 1'b0;
    dm_done_n   = 1'b0;
    rdata_n     = rdata;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;

    case (state)
      IDLE: begin
        if (win_valid_c) begin
          state_n   = CMD;
          bus_req_n = 1'b1;
          if (win_if_c) begin
            owner_n     = OWN_IF;
            if_gnt_n    = 1'b1;
            bus_we_n    = 1'b0;
            bus_addr_n  = if_addr;
            bus_wdata_n = '0;
            starve_n    = '0;
          end else begin
            owner_n     = OWN_DM;
            dm_gnt_n    = 1'b1;
            bus_we_n    = dm_we;
            bus_addr_n  = dm_addr;
            bus_wdata_n = dm_wdata;
            if (if_req && (starve_cnt < STARVE_W'(STARVE_MAX))) begin
              starve_n = starve_cnt + STARVE_W'(1);
            end
          end
        end
      end

      CMD: begin
        if (bus_ack) begin
          bus_req_n = 1'b0;
          if (bus_we) begin
            state_n   = DONE;
            if_done_n = (owner == OWN_IF);
            dm_done_n = (owner == OWN_DM);
          end else begin
            state_n = RDATA;
            beat_n  = '0;
          end
        end
      end

      RDATA: begin
        if (bus_rvalid) begin
          rdata_n     = bus_rdata;
          if_rvalid_n = (owner == OWN_IF);
          dm_rvalid_n = (owner == OWN_DM);
          beat_n      = beat_cnt + BEAT_W'(1);
          if (last_beat_c) begin
            state_n   = DONE;
            if_done_n = (owner == OWN_IF);
            dm_done_n = (owner == OWN_DM);
          end
        end
      end

      DONE: begin
        if_gnt_n = 1'b0;
        dm_gnt_n = 1'b0;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic grant_c, waiting_c;

  assign grant_c   = (state == IDLE) && win_valid_c;
  assign waiting_c = (if_req && !if_gnt) || (dm_req && !dm_gnt);

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_grants   <= '0;
      perf_dm_grants   <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (grant_c && win_if_c)  perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_c && !win_if_c) perf_dm_grants <= perf_dm_grants + 32'd1;
      if (waiting_c)            perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
